// File: rtl/matmul_result_writer_pkg.sv
// ---------------------------------------------------------------------------
// matmul_result_writer_pkg : shared FSM encoding and dimension helpers
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package matmul_result_writer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    DONE     = 2'd2,
    WAIT_CLR = 2'd3
  } wr_state_e;

  // Largest square matrix whose operand row fits in one bus word.
  function automatic int calc_max_dim(input int bus_w, input int data_w);
    return bus_w / data_w;
  endfunction

  function automatic int calc_addr_w(input int max_dim);
    int w;
    w = $clog2(max_dim * max_dim);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/matmul_result_writer.sv
// ---------------------------------------------------------------------------
// matmul_result_writer : captures a result matrix and streams it out row-major
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module matmul_result_writer
  import matmul_result_writer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 16,
  localparam int MAX_DIM   = calc_max_dim(BUS_WIDTH, DATA_WIDTH),
  localparam int ADDR_W    = calc_addr_w(MAX_DIM),
  localparam int N_ELEM    = MAX_DIM * MAX_DIM
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         finish_mul_i,
  input  logic [N_ELEM*BUS_WIDTH-1:0]  c_matrix_i,
  input  logic [N_ELEM-1:0]            flags_i,
  input  logic [1:0]                   n_dim_i,
  input  logic [1:0]                   m_dim_i,
  output logic                         wr_valid_o,
  input  logic                         wr_ready_i,
  output logic [ADDR_W-1:0]            wr_addr_o,
  output logic [BUS_WIDTH-1:0]         wr_data_o,
  output logic [N_ELEM-1:0]            flags_o,
  output logic                         busy_o,
  output logic                         finish_write_o
);

  wr_state_e                    state_q, state_d;
  logic [N_ELEM*BUS_WIDTH-1:0]  c_q, c_d;
  logic [N_ELEM-1:0]            flags_q, flags_d;
  logic [1:0]                   n_q, n_d, m_q, m_d;
  logic [1:0]                   row_q, row_d, col_q, col_d;

  logic [1:0]                   n_sat, m_sat;
  logic [N_ELEM-1:0]            flags_mask;
  logic [BUS_WIDTH-1:0]         elem [N_ELEM];
  logic [ADDR_W-1:0]            addr;
  logic                         hs, last;

  always_comb begin
    n_sat = (int'(n_dim_i) > MAX_DIM - 1) ? 2'(MAX_DIM - 1) : n_dim_i;
    m_sat = (int'(m_dim_i) > MAX_DIM - 1) ? 2'(MAX_DIM - 1) : m_dim_i;
    // Flag layout is column-major (r + c*MAX_DIM), unlike the data vector.
    flags_mask = '0;
    for (int r = 0; r < MAX_DIM; r++) begin
      for (int c = 0; c < MAX_DIM; c++) begin
        flags_mask[r + c*MAX_DIM] = flags_i[r + c*MAX_DIM]
                                    && (r <= int'(n_sat)) && (c <= int'(m_sat));
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N_ELEM; k++) begin
      elem[k] = c_q[k*BUS_WIDTH +: BUS_WIDTH];
    end
    addr = ADDR_W'(int'(row_q) * MAX_DIM + int'(col_q));
    hs   = (state_q == WRITE) && wr_ready_i;
    last = (row_q == n_q) && (col_q == m_q);
  end

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    flags_d = flags_q;
    n_d     = n_q;
    m_d     = m_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      IDLE: begin
        if (finish_mul_i) begin
          state_d = WRITE;
          c_d     = c_matrix_i;
          flags_d = flags_mask;
          n_d     = n_sat;
          m_d     = m_sat;
          row_d   = '0;
          col_d   = '0;
        end
      end
      WRITE: begin
        if (hs) begin
          if (last) begin
            state_d = DONE;
          end else if (col_q == m_q) begin
            col_d = '0;
            row_d = row_q + 2'd1;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
      end
      DONE:     state_d = WAIT_CLR;
      WAIT_CLR: if (!finish_mul_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      c_q     <= '0;
      flags_q <= '0;
      n_q     <= '0;
      m_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      flags_q <= flags_d;
      n_q     <= n_d;
      m_q     <= m_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Outputs decode registered state only, so reset clears them at once.
  always_comb begin
    wr_valid_o     = (state_q == WRITE);
    wr_addr_o      = wr_valid_o ? addr : '0;
    wr_data_o      = wr_valid_o ? elem[addr] : '0;
    flags_o        = flags_q;
    busy_o         = (state_q != IDLE);
    finish_write_o = (state_q == DONE);
  end

endmodule

`default_nettype wire

// File: tb/tb_matmul_result_writer.sv
// ---------------------------------------------------------------------------
// tb_matmul_result_writer : directed self-checking bench for the result writer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_matmul_result_writer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        finish_mul_i;
  logic [63:0] c_matrix_i;
  logic [3:0]  flags_i;
  logic [1:0]  n_dim_i, m_dim_i;
  logic        wr_valid_o, wr_ready_i;
  logic [1:0]  wr_addr_o;
  logic [15:0] wr_data_o;
  logic [3:0]  flags_o;
  logic        busy_o, finish_write_o;

  int checks   = 0;
  int failures = 0;

  logic [1:0]  q_addr[$];
  logic [15:0] q_data[$];
  int          fin_cycle;
  int          n_fin;
  bit          pat[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  always #5 clk_i = ~clk_i;

  matmul_result_writer #(.DATA_WIDTH(8), .BUS_WIDTH(16)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .finish_mul_i   (finish_mul_i),
    .c_matrix_i     (c_matrix_i),
    .flags_i        (flags_i),
    .n_dim_i        (n_dim_i),
    .m_dim_i        (m_dim_i),
    .wr_valid_o     (wr_valid_o),
    .wr_ready_i     (wr_ready_i),
    .wr_addr_o      (wr_addr_o),
    .wr_data_o      (wr_data_o),
    .flags_o        (flags_o),
    .busy_o         (busy_o),
    .finish_write_o (finish_write_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the first negedge after capture.
  task automatic start(input logic [63:0] cm, input logic [3:0] fl,
                       input logic [1:0] n, input logic [1:0] m);
    c_matrix_i   = cm;
    flags_i      = fl;
    n_dim_i      = n;
    m_dim_i      = m;
    wr_ready_i   = 1'b0;
    finish_mul_i = 1'b1;
    @(negedge clk_i);
    check("latency_valid", {63'd0, wr_valid_o}, 64'd1);
  endtask

  task automatic collect(input bit use_pat, input int budget);
    logic [1:0]  h_addr;
    logic [15:0] h_data;
    bit          holding;
    bit          rdy;
    q_addr.delete();
    q_data.delete();
    fin_cycle = -1;
    n_fin     = 0;
    holding   = 1'b0;
    h_addr    = '0;
    h_data    = '0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (holding) begin
        check("hold_addr", {62'd0, wr_addr_o}, {62'd0, h_addr});
        check("hold_data", {48'd0, wr_data_o}, {48'd0, h_data});
      end
      if (finish_write_o) begin
        n_fin++;
        if (fin_cycle < 0) fin_cycle = cyc;
      end
      rdy        = use_pat ? pat[cyc % 5] : 1'b1;
      wr_ready_i = rdy;
      holding    = wr_valid_o && !rdy;
      h_addr     = wr_addr_o;
      h_data     = wr_data_o;
      if (wr_valid_o && rdy) begin
        q_addr.push_back(wr_addr_o);
        q_data.push_back(wr_data_o);
      end
      @(negedge clk_i);
      if (fin_cycle >= 0) break;
    end
    if (fin_cycle < 0) check("finish_timeout", 64'd0, 64'd1);
    check("finish_one_cycle", {63'd0, finish_write_o}, 64'd0);
  endtask

  // Expected data words packed {d3,d2,d1,d0}; addresses run 0,1,2,...
  task automatic verify_writes(input string tag, input int n_exp, input logic [63:0] exp_d);
    logic [63:0] d;
    d = exp_d;
    check({tag, "_count"}, 64'(q_addr.size()), 64'(n_exp));
    for (int i = 0; i < n_exp && i < q_addr.size(); i++) begin
      check({tag, "_addr"}, {62'd0, q_addr[i]}, 64'(i));
      check({tag, "_data"}, {48'd0, q_data[i]}, {48'd0, d[i*16 +: 16]});
    end
  endtask

  task automatic release_finish();
    finish_mul_i = 1'b0;
    wr_ready_i   = 1'b0;
    repeat (2) @(negedge clk_i);
    check("idle_busy", {63'd0, busy_o}, 64'd0);
  endtask

  initial begin
    int valid_seen;
    int busy_low;
    int fin_seen;
    rst_i        = 1'b1;
    finish_mul_i = 1'b0;
    c_matrix_i   = '0;
    flags_i      = '0;
    n_dim_i      = '0;
    m_dim_i      = '0;
    wr_ready_i   = 1'b0;
    repeat (2) @(negedge clk_i);
    check("rst_valid",  {63'd0, wr_valid_o}, 64'd0);
    check("rst_addr",   {62'd0, wr_addr_o}, 64'd0);
    check("rst_data",   {48'd0, wr_data_o}, 64'd0);
    check("rst_flags",  {60'd0, flags_o}, 64'd0);
    check("rst_busy",   {63'd0, busy_o}, 64'd0);
    check("rst_finish", {63'd0, finish_write_o}, 64'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // 2x2 [[1,-2],[3,4]]; inputs scrambled and finish dropped after capture
    start({16'd4, 16'd3, 16'hFFFE, 16'd1}, 4'b0000, 2'd1, 2'd1);
    c_matrix_i   = 64'hDEAD_BEEF_1234_5678;
    flags_i      = 4'b1111;
    finish_mul_i = 1'b0;
    collect(1'b0, 20);
    verify_writes("basic", 4, {16'd4, 16'd3, 16'hFFFE, 16'd1});
    check("basic_fin_cycle", 64'(fin_cycle), 64'd4);
    check("basic_flags", {60'd0, flags_o}, 64'd0);
    release_finish();

    // 1x2 with flag masking
    start({16'hAAAA, 16'hBBBB, 16'd6, 16'd5}, 4'b1111, 2'd0, 2'd1);
    collect(1'b0, 20);
    verify_writes("row1", 2, {16'd0, 16'd0, 16'd6, 16'd5});
    check("row1_fin_cycle", 64'(fin_cycle), 64'd2);
    check("row1_flags", {60'd0, flags_o}, 64'b0101);
    release_finish();
    check("flags_held", {60'd0, flags_o}, 64'b0101);

    // backpressure pattern 0,1,0,0,1
    start({16'd40, 16'd30, 16'd20, 16'd10}, 4'b0010, 2'd1, 2'd1);
    collect(1'b1, 40);
    verify_writes("bp", 4, {16'd40, 16'd30, 16'd20, 16'd10});
    check("bp_fin_cycle", 64'(fin_cycle), 64'd10);
    check("bp_flags", {60'd0, flags_o}, 64'b0010);
    release_finish();

    // finish_mul_i held high after completion: no re-capture
    start({16'd7, 16'd8, 16'd9, 16'd11}, 4'b0000, 2'd1, 2'd1);
    collect(1'b0, 20);
    verify_writes("hold1", 4, {16'd7, 16'd8, 16'd9, 16'd11});
    valid_seen = 0;
    busy_low   = 0;
    for (int i = 0; i < 20; i++) begin
      if (wr_valid_o) valid_seen++;
      if (!busy_o) busy_low++;
      @(negedge clk_i);
    end
    check("hold_no_valid", 64'(valid_seen), 64'd0);
    check("hold_busy", 64'(busy_low), 64'd0);
    finish_mul_i = 1'b0;
    @(negedge clk_i);
    start({16'd100, 16'd200, 16'd300, 16'd400}, 4'b0000, 2'd1, 2'd1);
    collect(1'b0, 20);
    verify_writes("hold2", 4, {16'd100, 16'd200, 16'd300, 16'd400});
    check("hold2_fins", 64'(n_fin), 64'd1);
    release_finish();

    // reset after the 2nd handshake
    start({16'd14, 16'd13, 16'd12, 16'd11}, 4'b1001, 2'd1, 2'd1);
    check("pre_rst_flags", {60'd0, flags_o}, 64'b1001);
    wr_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("pre_rst_addr", {62'd0, wr_addr_o}, 64'd2);
    wr_ready_i = 1'b0;
    rst_i      = 1'b1;
    #1;
    check("arst_valid",  {63'd0, wr_valid_o}, 64'd0);
    check("arst_addr",   {62'd0, wr_addr_o}, 64'd0);
    check("arst_data",   {48'd0, wr_data_o}, 64'd0);
    check("arst_flags",  {60'd0, flags_o}, 64'd0);
    check("arst_busy",   {63'd0, busy_o}, 64'd0);
    check("arst_finish", {63'd0, finish_write_o}, 64'd0);
    @(negedge clk_i);
    rst_i        = 1'b0;
    finish_mul_i = 1'b0;
    fin_seen     = 0;
    for (int i = 0; i < 6; i++) begin
      if (finish_write_o || wr_valid_o) fin_seen++;
      @(negedge clk_i);
    end
    check("arst_no_finish", 64'(fin_seen), 64'd0);
    start({16'd24, 16'd23, 16'd22, 16'd21}, 4'b0000, 2'd1, 2'd1);
    collect(1'b0, 20);
    verify_writes("restart", 4, {16'd24, 16'd23, 16'd22, 16'd21});
    release_finish();

    // oversize dimensions saturate to 2x2
    start({16'h8000, 16'h7FFF, 16'd2, 16'hFFFF}, 4'b1111, 2'd3, 2'd3);
    collect(1'b0, 20);
    verify_writes("sat", 4, {16'h8000, 16'h7FFF, 16'd2, 16'hFFFF});
    check("sat_fin_cycle", 64'(fin_cycle), 64'd4);
    check("sat_flags", {60'd0, flags_o}, 64'b1111);
    release_finish();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/matmul_result_writer.md
MATMUL_RESULT_WRITER -- requirements
Module: matmul_result_writer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the operand element width.
REQ-002 The block SHALL have parameter BUS_WIDTH, default 16, giving the result element and write-bus width.
REQ-003 The block SHALL derive local constants MAX_DIM = BUS_WIDTH/DATA_WIDTH and ADDR_W = max(1, clog2(MAX_DIM*MAX_DIM)).
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port finish_mul_i, input, 1 bit: the multiplier result is complete and stable.
REQ-007 The block SHALL have port c_matrix_i, input, MAX_DIM*MAX_DIM*BUS_WIDTH bits: the result matrix; element (r,c) occupies bits [(r*MAX_DIM+c+1)*BUS_WIDTH-1 -: BUS_WIDTH].
REQ-008 The block SHALL have port flags_i, input, MAX_DIM*MAX_DIM bits: per-PE overflow; element (r,c) is bit r+c*MAX_DIM.
REQ-009 The block SHALL have ports n_dim_i and m_dim_i, input, 2 bits each: result rows-1 and columns-1.
REQ-010 The block SHALL have port wr_valid_o, output, 1 bit: a write request is presented.
REQ-011 The block SHALL have port wr_ready_i, input, 1 bit: the sink accepts the write.
REQ-012 The block SHALL have port wr_addr_o, output, ADDR_W bits: element address, equal to r*MAX_DIM+c.
REQ-013 The block SHALL have port wr_data_o, output, BUS_WIDTH bits: the signed element value.
REQ-014 The block SHALL have port flags_o, output, MAX_DIM*MAX_DIM bits: the captured, masked overflow flags.
REQ-015 The block SHALL have port busy_o, output, 1 bit: the block is not in IDLE.
REQ-016 The block SHALL have port finish_write_o, output, 1 bit: one-cycle pulse marking that all elements are written.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, WRITE, DONE, WAIT_CLR.
REQ-018 In IDLE, when finish_mul_i is sampled high, the block SHALL go to WRITE and register c_matrix_i, flags_i, n_dim_i and m_dim_i.
REQ-019 Each captured dimension SHALL saturate to MAX_DIM-1.
REQ-020 The captured flags SHALL be masked: bits outside r<=n and c<=m are zeroed.
REQ-021 The first wr_valid_o SHALL assert in the cycle after finish_mul_i is sampled (latency 1).
REQ-022 In WRITE, wr_valid_o SHALL be 1 and wr_addr_o/wr_data_o SHALL hold steady until a cycle with wr_valid_o && wr_ready_i.
REQ-023 Element order SHALL be row-major, starting at (0,0): the column increments, and at c==m it wraps to 0 while the row increments.
REQ-024 The handshake of element (n,m) SHALL move the FSM to DONE.
REQ-025 With wr_ready_i held high, the block SHALL transfer one element per cycle, (n+1)*(m+1) cycles in total.
REQ-026 In DONE, finish_write_o SHALL be 1 for exactly one cycle, and the next state SHALL be WAIT_CLR.
REQ-027 In WAIT_CLR, the block SHALL stay until finish_mul_i is sampled low, then go to IDLE; no re-capture SHALL occur while finish_mul_i stays high.
REQ-028 finish_mul_i falling during WRITE SHALL be ignored; the captured matrix SHALL still be written out completely.
REQ-029 Changes on c_matrix_i or flags_i after capture SHALL NOT affect wr_data_o or flags_o.
REQ-030 flags_o SHALL hold its captured value until the next capture.
REQ-031 Outside WRITE, wr_valid_o SHALL be 0, and wr_addr_o/wr_data_o SHALL be 0.

Reset
REQ-032 rst_i high SHALL immediately force state IDLE and all outputs to 0: wr_valid_o, wr_addr_o, wr_data_o, flags_o, busy_o, finish_write_o.
REQ-033 rst_i high SHALL immediately clear all capture registers and the row/column counters.
REQ-034 Reset asserted mid-WRITE SHALL abort the transfer with no finish_write_o pulse.
REQ-035 After reset is released, the next capture SHALL follow REQ-018.

Structure
REQ-036 The FSM state encoding and the MAX_DIM/ADDR_W derivation SHALL live in the shared matmul package, for use by the control block and by benches.
REQ-037 The block SHALL be a single module with no sub-modules; element selection SHALL be an indexed mux on the captured vector.

Verification
REQ-038 n=1, m=1, c=[[1,-2],[3,4]], ready=1 -> addr 0,1,2,3 with data 1,-2,3,4 on consecutive cycles, starting 1 cycle after finish_mul_i; finish_write_o pulses the next cycle.
REQ-039 n=0, m=1, c=[[5,6],[x,x]] -> exactly 2 writes, addr 0 data 5 then addr 1 data 6; flags_i=4'b1111 -> flags_o=4'b0101.
REQ-040 ready toggling 0,1,0,0,1,... -> every element is held until accepted; no element is skipped or duplicated; the order is unchanged.
REQ-041 finish_mul_i held high for 20 cycles after finish_write_o -> exactly one transfer; after finish_mul_i goes low then high again -> a second transfer occurs.
REQ-042 rst_i pulsed after the 2nd handshake -> all outputs are 0 immediately and finish_write_o never pulses; a new finish_mul_i then restarts the transfer at addr 0.
REQ-043 n_dim_i=3, m_dim_i=3 with MAX_DIM=2 -> saturates to 2x2, giving exactly 4 writes.
